// File: rtl/mouse_frame_accum_if.sv
// Signal bundle between the HPS mouse source / video timing and mouse_frame_accum.
// The master drives raw mouse events, VDE and EN; the slave returns the per-frame word and buttons.
interface mouse_frame_accum_if;
    logic [24:0] PS2_MOUSE;
    logic        VDE;
    logic        EN;
    logic [24:0] MOUSE_OUT;
    logic [2:0]  BTN;

    modport master (
        output PS2_MOUSE,
        output VDE,
        output EN,
        input  MOUSE_OUT,
        input  BTN
    );

    modport slave (
        input  PS2_MOUSE,
        input  VDE,
        input  EN,
        output MOUSE_OUT,
        output BTN
    );
endinterface

// File: rtl/mouse_frame_accum.sv
// Accumulates toggle-qualified PS/2 mouse deltas and emits one clamped packet per VDE falling edge.
// Optional feature: define MOUSE_ACCEL_EN to double deltas of magnitude 8 or more before accumulation.
module mouse_frame_accum #(
    parameter int ACC_W   = 12,
    parameter int OVF_MAG = 255
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    mouse_frame_accum_if.slave   bus
);

    // Deltas are handled two bits wider than the accumulator so sums never wrap before clamping.
    localparam int WW = ACC_W + 2;

    localparam logic signed [WW-1:0]    OVF_W      = WW'(OVF_MAG);
    localparam logic signed [WW-1:0]    ACC_MAX_W  = WW'((1 << (ACC_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] OUT_HI_A   = ACC_W'(255);
    localparam logic signed [ACC_W-1:0] OUT_LO_A   = ACC_W'(-256);
`ifdef MOUSE_ACCEL_EN
    localparam logic signed [WW-1:0]    ACCEL_MIN  = WW'(8);
`endif

    function automatic logic signed [WW-1:0] delta_decode(
        input logic       sgn,
        input logic       ovf,
        input logic [7:0] mag
    );
        logic signed [WW-1:0] d;
        if (ovf) begin
            if (sgn) begin
                d = -OVF_W;
            end else begin
                d = OVF_W;
            end
        end else begin
            d = {{(WW-8){sgn}}, mag};
        end
        return d;
    endfunction

`ifdef MOUSE_ACCEL_EN
    function automatic logic signed [WW-1:0] accel_delta(input logic signed [WW-1:0] d);
        logic signed [WW-1:0] r;
        if ((d >= ACCEL_MIN) || (d <= -ACCEL_MIN)) begin
            r = d <<< 1;
            if (r > OVF_W) begin
                r = OVF_W;
            end else if (r < -OVF_W) begin
                r = -OVF_W;
            end else begin
                r = d <<< 1;
            end
        end else begin
            r = d;
        end
        return r;
    endfunction
`endif

    // Symmetric saturation: the most negative code of the accumulator is never produced.
    function automatic logic signed [ACC_W-1:0] sat_add(
        input logic signed [ACC_W-1:0] acc,
        input logic signed [WW-1:0]    d
    );
        logic signed [WW-1:0]    sum;
        logic signed [ACC_W-1:0] res;
        sum = {{2{acc[ACC_W-1]}}, acc} + d;
        if (sum > ACC_MAX_W) begin
            res = ACC_MAX_W[ACC_W-1:0];
        end else if (sum < -ACC_MAX_W) begin
            res = -ACC_MAX_W[ACC_W-1:0];
        end else begin
            res = sum[ACC_W-1:0];
        end
        return res;
    endfunction

    function automatic logic signed [8:0] clamp_out(input logic signed [ACC_W-1:0] acc);
        logic signed [8:0] res;
        if (acc > OUT_HI_A) begin
            res = 9'h0FF;
        end else if (acc < OUT_LO_A) begin
            res = 9'h100;
        end else begin
            res = acc[8:0];
        end
        return res;
    endfunction

    logic                    tog_r;
    logic                    vde_r;
    logic signed [ACC_W-1:0] acc_x_r;
    logic signed [ACC_W-1:0] acc_y_r;
    logic [24:0]             mouse_out_r;
    logic [2:0]              btn_r;
    logic [2:0]              btn_sent_r;

    logic                    event_s;
    logic                    fall_s;
    logic                    need_s;
    logic                    emit_s;
    logic signed [WW-1:0]    dx_s;
    logic signed [WW-1:0]    dy_s;
    logic signed [8:0]       out_x_s;
    logic signed [8:0]       out_y_s;
    logic signed [ACC_W-1:0] sum_x_s;
    logic signed [ACC_W-1:0] sum_y_s;
    logic signed [ACC_W-1:0] acc_x_s;
    logic signed [ACC_W-1:0] acc_y_s;
    logic [24:0]             mouse_out_s;
    logic [2:0]              btn_s;
    logic [2:0]              btn_sent_s;
    logic                    unused_s;

    // Bit 3 of the raw word carries no information for this stage.
    assign unused_s = bus.PS2_MOUSE[3];

    // Event decode, delta scaling, emission decision and next-state computation.
    always_comb begin
        event_s = bus.PS2_MOUSE[24] ^ tog_r;
        fall_s  = bus.EN & ~bus.VDE & vde_r;
        need_s  = (acc_x_r != {ACC_W{1'b0}}) | (acc_y_r != {ACC_W{1'b0}}) | (btn_r != btn_sent_r);
        emit_s  = fall_s & need_s;

`ifdef MOUSE_ACCEL_EN
        dx_s = accel_delta(delta_decode(bus.PS2_MOUSE[4], bus.PS2_MOUSE[6], bus.PS2_MOUSE[15:8]));
        dy_s = accel_delta(delta_decode(bus.PS2_MOUSE[5], bus.PS2_MOUSE[7], bus.PS2_MOUSE[23:16]));
`else
        dx_s = delta_decode(bus.PS2_MOUSE[4], bus.PS2_MOUSE[6], bus.PS2_MOUSE[15:8]);
        dy_s = delta_decode(bus.PS2_MOUSE[5], bus.PS2_MOUSE[7], bus.PS2_MOUSE[23:16]);
`endif

        // The packet is clamped from the pre-event value; a same-cycle delta lands in the residual.
        out_x_s = clamp_out(acc_x_r);
        out_y_s = clamp_out(acc_y_r);

        if (event_s) begin
            sum_x_s = sat_add(acc_x_r, dx_s);
            sum_y_s = sat_add(acc_y_r, dy_s);
        end else begin
            sum_x_s = acc_x_r;
            sum_y_s = acc_y_r;
        end

        if (!bus.EN) begin
            acc_x_s = {ACC_W{1'b0}};
            acc_y_s = {ACC_W{1'b0}};
        end else if (emit_s) begin
            acc_x_s = sum_x_s - {{(ACC_W-9){out_x_s[8]}}, out_x_s};
            acc_y_s = sum_y_s - {{(ACC_W-9){out_y_s[8]}}, out_y_s};
        end else begin
            acc_x_s = sum_x_s;
            acc_y_s = sum_y_s;
        end

        if (emit_s) begin
            mouse_out_s = {~mouse_out_r[24], out_y_s[7:0], out_x_s[7:0], 2'b00,
                           out_y_s[8], out_x_s[8], 1'b0, btn_r};
            btn_sent_s  = btn_r;
        end else begin
            mouse_out_s = mouse_out_r;
            btn_sent_s  = btn_sent_r;
        end

        if (event_s) begin
            btn_s = bus.PS2_MOUSE[2:0];
        end else begin
            btn_s = btn_r;
        end
    end

    // State registers; reset leaves toggle copy at 0 so a pending toggle=1 counts as an event.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            tog_r       <= 1'b0;
            vde_r       <= 1'b0;
            acc_x_r     <= {ACC_W{1'b0}};
            acc_y_r     <= {ACC_W{1'b0}};
            mouse_out_r <= 25'h0000000;
            btn_r       <= 3'b000;
            btn_sent_r  <= 3'b000;
        end else begin
            tog_r       <= bus.PS2_MOUSE[24];
            vde_r       <= bus.VDE;
            acc_x_r     <= acc_x_s;
            acc_y_r     <= acc_y_s;
            mouse_out_r <= mouse_out_s;
            btn_r       <= btn_s;
            btn_sent_r  <= btn_sent_s;
        end
    end

    assign bus.MOUSE_OUT = mouse_out_r;
    assign bus.BTN       = btn_r;

endmodule

// File: tb/tb_mouse_frame_accum.sv
// Directed and randomized bench for mouse_frame_accum against an integer-arithmetic frame model.
module tb_mouse_frame_accum;

    localparam int ACC_W   = 12;
    localparam int OVF_MAG = 255;
    localparam int ACC_MAX = (1 << (ACC_W - 1)) - 1;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;

    always #5 CLK = ~CLK;

    mouse_frame_accum_if bus ();

    mouse_frame_accum #(.ACC_W(ACC_W), .OVF_MAG(OVF_MAG)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    int vectors = 0;
    int errors  = 0;

    int          m_ax, m_ay;
    logic [2:0]  m_btn, m_sent;
    logic [24:0] m_out;
    logic        m_tog, m_vde;

    logic        tgl;
    logic [24:0] cur_ps2;
    logic        cur_vde, cur_en;

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic int dec(input logic s, input logic ov, input logic [7:0] m);
        int d;
        if (ov) d = s ? -OVF_MAG : OVF_MAG;
        else    d = s ? int'(m) - 256 : int'(m);
`ifdef MOUSE_ACCEL_EN
        if (d >= 8 || d <= -8) d = clampi(2 * d, -OVF_MAG, OVF_MAG);
`endif
        return d;
    endfunction

    function automatic logic [24:0] mk_word(input logic t, input logic [2:0] b, input int dx,
                                            input int dy, input logic ovx, input logic ovy);
        logic [8:0] x9, y9;
        x9 = 9'(dx);
        y9 = 9'(dy);
        return {t, y9[7:0], x9[7:0], ovy, ovx, y9[8], x9[8], 1'b0, b};
    endfunction

    task automatic model_reset();
        m_ax = 0; m_ay = 0; m_btn = 3'b000; m_sent = 3'b000;
        m_out = 25'h0; m_tog = 1'b0; m_vde = 1'b0;
    endtask

    // One clock of the frame model: packet from the pre-event totals, then fold in the new delta.
    task automatic model_step(input logic [24:0] w, input logic vde, input logic en);
        logic ev, emit;
        int ox, oy;
        ev   = (w[24] != m_tog);
        emit = en && !vde && m_vde && (m_ax != 0 || m_ay != 0 || m_btn != m_sent);
        ox = clampi(m_ax, -256, 255);
        oy = clampi(m_ay, -256, 255);
        if (emit) begin
            m_out  = {~m_out[24], 8'(oy), 8'(ox), 2'b00, oy < 0, ox < 0, 1'b0, m_btn};
            m_sent = m_btn;
        end
        if (!en) begin
            m_ax = 0; m_ay = 0;
        end else begin
            if (ev) begin
                m_ax = clampi(m_ax + dec(w[4], w[6], w[15:8]), -ACC_MAX, ACC_MAX);
                m_ay = clampi(m_ay + dec(w[5], w[7], w[23:16]), -ACC_MAX, ACC_MAX);
            end
            if (emit) begin
                m_ax = m_ax - ox;
                m_ay = m_ay - oy;
            end
        end
        if (ev) m_btn = w[2:0];
        m_tog = w[24];
        m_vde = vde;
    endtask

    task automatic check_model(input string tag);
        vectors++;
        assert (bus.MOUSE_OUT === m_out) else begin
            errors++;
            $error("FAIL %s MOUSE_OUT observed=%h expected=%h", tag, bus.MOUSE_OUT, m_out);
        end
        vectors++;
        assert (bus.BTN === m_btn) else begin
            errors++;
            $error("FAIL %s BTN observed=%b expected=%b", tag, bus.BTN, m_btn);
        end
    endtask

    task automatic chk(input string tag, input logic [24:0] obs, input logic [24:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [24:0] w, input logic vde, input logic en, input string tag);
        @(negedge CLK);
        RESET_N = 1'b1;
        cur_ps2 = w; cur_vde = vde; cur_en = en;
        bus.PS2_MOUSE = w; bus.VDE = vde; bus.EN = en;
        model_step(w, vde, en);
        @(posedge CLK);
        #1;
        check_model(tag);
    endtask

    task automatic ev(input logic [2:0] b, input int dx, input int dy, input logic ovx,
                      input logic ovy, input logic vde, input logic en, input string tag);
        tgl = ~tgl;
        step(mk_word(tgl, b, dx, dy, ovx, ovy), vde, en, tag);
    endtask

    task automatic frame(input logic en, input string tag);
        step(cur_ps2, 1'b1, en, tag);
        step(cur_ps2, 1'b0, en, tag);
    endtask

    task automatic do_reset();
        #2;
        RESET_N = 1'b0;
        #1;
        chk("rst_out", bus.MOUSE_OUT, 25'h0);
        chk("rst_btn", 25'(bus.BTN), 25'h0);
        model_reset();
    endtask

    initial begin
        int vcnt;
        logic [24:0] w;
        tgl = 1'b0;
        cur_ps2 = 25'h0; cur_vde = 1'b0; cur_en = 1'b0;
        bus.PS2_MOUSE = 25'h0; bus.VDE = 1'b0; bus.EN = 1'b0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_out", bus.MOUSE_OUT, 25'h0);
        chk("reset_btn", 25'(bus.BTN), 25'h0);

        // Three +5 events -> one packet of +15.
        step(cur_ps2, 1'b1, 1'b1, "idle");
        step(cur_ps2, 1'b1, 1'b1, "idle");
        repeat (3) ev(3'b000, 5, 0, 1'b0, 1'b0, 1'b1, 1'b1, "x3_ev");
        frame(1'b1, "x3_frame");
        chk("x3_dx", 25'(bus.MOUSE_OUT[15:8]), 25'h0F);
        chk("x3_sign", 25'(bus.MOUSE_OUT[4]), 25'h0);
        chk("x3_tog", 25'(bus.MOUSE_OUT[24]), 25'h1);
        frame(1'b1, "x3_empty");

        // +700 drains as 255, 255, 190 and then nothing.
        repeat (7) ev(3'b000, 100, 0, 1'b0, 1'b0, 1'b0, 1'b1, "b700_ev");
        frame(1'b1, "b700_f1");
        chk("b700_f1_dx", 25'(bus.MOUSE_OUT[15:8]), 25'hFF);
        frame(1'b1, "b700_f2");
        chk("b700_f2_dx", 25'(bus.MOUSE_OUT[15:8]), 25'hFF);
        frame(1'b1, "b700_f3");
        chk("b700_f3_dx", 25'(bus.MOUSE_OUT[15:8]), 25'hBE);
        frame(1'b1, "b700_f4");

        // Delta arriving on the falling-edge cycle goes to the next frame.
        ev(3'b000, 0, -10, 1'b0, 1'b0, 1'b1, 1'b1, "sim_pre");
        step(cur_ps2, 1'b1, 1'b1, "sim_hi");
        ev(3'b000, 0, -3, 1'b0, 1'b0, 1'b0, 1'b1, "sim_fall");
        chk("sim_dy", 25'(bus.MOUSE_OUT[23:16]), 25'hF6);
        chk("sim_sign", 25'(bus.MOUSE_OUT[5]), 25'h1);
        frame(1'b1, "sim_next");
        chk("sim_next_dy", 25'(bus.MOUSE_OUT[23:16]), 25'hFD);

        // Overflow substitution and the optional doubling.
        ev(3'b000, -1, 0, 1'b1, 1'b0, 1'b1, 1'b1, "ovf_ev");
        frame(1'b1, "ovf_frame");
        chk("ovf_dx", 25'(bus.MOUSE_OUT[15:8]), 25'h01);
        chk("ovf_sign", 25'(bus.MOUSE_OUT[4]), 25'h1);
        ev(3'b000, 10, 0, 1'b0, 1'b0, 1'b1, 1'b1, "acc10_ev");
        frame(1'b1, "acc10_frame");
`ifdef MOUSE_ACCEL_EN
        chk("acc10_dx", 25'(bus.MOUSE_OUT[15:8]), 25'h14);
`else
        chk("acc10_dx", 25'(bus.MOUSE_OUT[15:8]), 25'h0A);
`endif
        ev(3'b000, 7, 0, 1'b0, 1'b0, 1'b1, 1'b1, "acc7_ev");
        frame(1'b1, "acc7_frame");
        chk("acc7_dx", 25'(bus.MOUSE_OUT[15:8]), 25'h07);

        // Button change with no motion still produces a packet.
        ev(3'b001, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, "btn_ev");
        frame(1'b1, "btn_frame");
        chk("btn_bits", 25'(bus.MOUSE_OUT[2:0]), 25'h1);
        chk("btn_motion", 25'(bus.MOUSE_OUT[23:8]), 25'h0);

        // EN low: deltas dropped, buttons tracked, no emission.
        step(cur_ps2, 1'b1, 1'b0, "en_lo");
        ev(3'b101, 50, 20, 1'b0, 1'b0, 1'b1, 1'b0, "en_lo_ev");
        chk("en_lo_btn", 25'(bus.BTN), 25'h5);
        frame(1'b0, "en_lo_frame");
        frame(1'b1, "en_hi_frame");
        chk("en_hi_dx", 25'(bus.MOUSE_OUT[15:8]), 25'h0);
        chk("en_hi_btn", 25'(bus.MOUSE_OUT[2:0]), 25'h5);

        // Mid-frame reset discards pending motion.
        ev(3'b101, 40, 0, 1'b0, 1'b0, 1'b1, 1'b1, "rst_ev");
        step(cur_ps2, 1'b1, 1'b1, "rst_hold");
        do_reset();
        tgl = 1'b0;
        cur_ps2 = 25'h0;
        bus.PS2_MOUSE = 25'h0;
        step(cur_ps2, 1'b1, 1'b1, "rst_rel");
        frame(1'b1, "rst_frame");
        chk("rst_frame_out", bus.MOUSE_OUT, 25'h0);

        // A toggle=1 word present at release counts as one event.
        do_reset();
        tgl = 1'b1;
        w = mk_word(1'b1, 3'b010, 3, 0, 1'b0, 1'b0);
        bus.PS2_MOUSE = w;
        step(w, 1'b1, 1'b1, "rel_ev");
        frame(1'b1, "rel_frame");
        chk("rel_dx", 25'(bus.MOUSE_OUT[15:8]), 25'h03);
        chk("rel_btn", 25'(bus.MOUSE_OUT[2:0]), 25'h2);

        // Randomized traffic with random frame lengths and occasional EN drops.
        vcnt = 4;
        for (int i = 0; i < 3000; i++) begin
            logic vde_n, en_n;
            int r;
            vde_n = cur_vde;
            if (vcnt == 0) begin
                vde_n = ~cur_vde;
                vcnt  = $urandom_range(1, 12);
            end else begin
                vcnt--;
            end
            en_n = ($urandom_range(0, 19) != 0);
            r = $urandom_range(0, 5);
            w = 25'($urandom);
            w[6] = ($urandom_range(0, 15) == 0);
            w[7] = ($urandom_range(0, 15) == 0);
            if (r < 2) begin
                tgl = ~tgl;
                w[24] = tgl;
            end else if (r == 2) begin
                w[24] = tgl;
            end else begin
                w = cur_ps2;
            end
            step(w, vde_n, en_n, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/mouse_frame_accum.md
# mouse_frame_accum

Upstream stage for the SNES lightgun/mouse port logic. It takes raw PS/2 mouse events from the HPS (toggle-qualified, 25-bit format) and accumulates X/Y motion in saturating signed accumulators. Once per video frame, at the VDE falling edge, it emits one clamped, re-packed 25-bit mouse word with a flipped toggle bit. The lightgun's cursor therefore advances exactly once per frame, with no lost motion and no mid-frame jumps.

## Interface
Parameters:
- ACC_W, 12: accumulator width in bits, signed two's complement; legal values 10..16.
- OVF_MAG, 255: magnitude substituted for a delta whose PS/2 overflow bit is set.

Ports:
- CLK, in, 1: system clock.
- RESET_N, in, 1: asynchronous, active-low reset.
- PS2_MOUSE, in, 25: raw HPS word.
  - [24] toggle; [2:0] buttons; [4] X sign; [5] Y sign; [6] X overflow; [7] Y overflow; [15:8] dX; [23:16] dY.
- VDE, in, 1: vertical display enable, quasi-static in the CLK domain.
- EN, in, 1: enable. When low, accumulators are cleared and emission stops.
- MOUSE_OUT, out, 25: same format as PS2_MOUSE.
  - [7:6] are always 0.
  - [24] flips once per emitted packet.
- BTN, out, 3: buttons from the last accepted input event.

## Operation
Input event:
- An event is detected when PS2_MOUSE[24] differs from its registered copy.
- dx is the 9-bit signed value {[4],[15:8]}; dy is {[5],[23:16]}.
- If the overflow bit is set, the delta is replaced by +OVF_MAG, or by −OVF_MAG when the sign bit is set.
- Deltas are sign-extended to ACC_W and added to acc_x/acc_y with saturation at ±(2^(ACC_W−1)−1). The negative limit is symmetric.
- BTN is updated from [2:0] on every event.

Emission:
- Trigger: VDE falling edge (VDE low and registered VDE high) while EN is high.
- Packet required if acc_x≠0, acc_y≠0, or BTN≠btn_sent.
- out_x = clamp(acc_x, −256, +255); out_y = clamp(acc_y, −256, +255).
- MOUSE_OUT fields:
  - [15:8] = out_x[7:0]; [4] = out_x[8].
  - [23:16] = out_y[7:0]; [5] = out_y[8].
  - [2:0] = BTN; [24] flips.
- acc_x/acc_y are reduced by out_x/out_y; any residual carries into later frames.
- btn_sent takes the value of BTN.
- If no packet is required, MOUSE_OUT and the toggle are unchanged.

Simultaneous event and emission in the same cycle:
- The accumulator's next value is sat(acc + d) − out, where out is clamped from the pre-event acc.
- The new delta therefore appears in the next frame's packet and is never lost.

EN low:
- acc_x, acc_y are held at 0 and incoming deltas are discarded.
- BTN still tracks input events.
- No emission; MOUSE_OUT is held.

Reset (RESET_N low, at any time, including mid-frame):
- MOUSE_OUT=0, BTN=0, btn_sent=0, acc_x=acc_y=0.
- Registered toggle copy=0; registered VDE=0.
- After release, a PS2_MOUSE[24]=1 already present at reset release counts as one event.

## Timing
- Event detect in cycle m; accumulator updated at the m+1 edge.
- VDE falling edge detected in cycle n; MOUSE_OUT valid from n+1.
- Minimum spacing between output toggles is one video frame.
- No backpressure: the consumer samples the toggle edge.
- Input events may arrive every cycle; each toggle flip counts as one event.

## Configuration
- MOUSE_ACCEL_EN defined: each incoming delta with |d| ≥ 8 is doubled before accumulation, saturating to ±OVF_MAG.
  - Deltas with |d| < 8 pass through unchanged.
  - Overflow substitution happens before doubling.
- MOUSE_ACCEL_EN undefined: deltas are accumulated unscaled. The doubling logic is absent.

## Test plan
- Three events, dx=+5 each, then VDE falls → one packet with [15:8]=0x0F, [4]=0, toggle flips once; acc_x=0.
- Events totalling dx=+700 within one frame → packets of +255, +255, then +190 on successive VDE falls; a fourth frame emits no toggle.
- Event dy=−3 in the same cycle the VDE falling edge is detected, with acc_y=−10 → packet out_y=−10 ([5]=1, [23:16]=0xF6); next frame emits out_y=−3.
- X overflow bit set with sign=1 → acc_x=−255; with MOUSE_ACCEL_EN, dx=+10 → acc_x=+20, dx=+7 → acc_x=+7.
- Button change only (0→3'b001, no motion), then VDE falls → packet with zero deltas, [2:0]=001, toggle flips.
- RESET_N pulsed low mid-frame with acc_x=+40 → MOUSE_OUT=0 and BTN=0 immediately; next VDE fall emits nothing. EN low → deltas ignored and no toggle.
